// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch program counter with stall, branch redirect, flush and optional return-address stack.
// The RAS is compiled in only when the PC_RAS_EN macro is defined.
module pc_seq_unit #(
    parameter int               ISIZE     = 16,
    parameter logic [ISIZE-1:0] RESET_VEC = '0,
    parameter int               STEP      = 1,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic [ISIZE-1:0] branch_target_i,
    input  logic             call_i,
    input  logic             ret_i,
    output logic [ISIZE-1:0] pc_o,
    output logic [ISIZE-1:0] pc_plus_o,
    output logic             flush_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ret_err_o
);
    logic [ISIZE-1:0] pc_q, pc_d, ras_top;
    logic             flush_q, flush_d, ret_hit;

    assign pc_plus_o = pc_q + ISIZE'(STEP);
    assign pc_o      = pc_q;
    assign flush_o   = flush_q;

`ifdef PC_RAS_EN
    localparam int            PW   = $clog2(RAS_DEPTH);
    localparam int            CW   = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [ISIZE-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    sp_q, sp_d, sp_inc, sp_dec;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d, push;

    // sp_q points at the next free slot; the stack wraps so a push when full drops the oldest entry
    assign sp_inc      = (sp_q == LAST) ? '0 : sp_q + PW'(1);
    assign sp_dec      = (sp_q == '0) ? LAST : sp_q - PW'(1);
    assign ras_top     = ras_q[sp_dec];
    assign ras_empty_o = (cnt_q == '0);
    assign ras_full_o  = (cnt_q == FULL);
    assign ret_err_o   = err_q;
    assign push        = branch_i & call_i;
    assign ret_hit     = ret_i & ~branch_i & ~ras_empty_o;

    // stack pointer, occupancy and sticky return-error next state
    always_comb begin
        sp_d  = push ? sp_inc : ret_hit ? sp_dec : sp_q;
        cnt_d = push ? (ras_full_o ? cnt_q : cnt_q + CW'(1)) : ret_hit ? cnt_q - CW'(1) : cnt_q;
        err_d = err_q | (ret_i & ~branch_i & ras_empty_o);
    end

    // stack control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // return-address storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (!rst && push) ras_q[sp_q] <= pc_plus_o;
    end
`else
    logic unused_ok;

    assign unused_ok   = ^{call_i, ret_i} ^ (RAS_DEPTH > 1);
    assign ras_top     = '0;
    assign ret_hit     = 1'b0;
    assign ras_empty_o = 1'b1;
    assign ras_full_o  = 1'b0;
    assign ret_err_o   = 1'b0;
`endif

    // next PC: branch beats return, redirects beat stall, otherwise advance by STEP
    always_comb begin
        pc_d    = branch_i ? branch_target_i : ret_hit ? ras_top : stall_i ? pc_q : pc_plus_o;
        flush_d = branch_i | ret_hit;
    end

    // PC and flush registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed self-checking bench for pc_seq_unit (RAS checks only when PC_RAS_EN is defined).
module tb_pc_seq_unit;
    logic        clk = 1'b0;
    logic        rst, stall, branch, call, ret;
    logic [15:0] target;
    logic [15:0] pc, pc_plus, pc2, pc_plus2;
    logic        flush, empty, full, err;
    logic        flush2, empty2, full2, err2;
    int          vec = 0;
    int          miss = 0;

    always #5 clk = ~clk;

    pc_seq_unit #(.ISIZE(16), .RESET_VEC(16'h0010), .STEP(1), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch),
        .branch_target_i(target), .call_i(call), .ret_i(ret),
        .pc_o(pc), .pc_plus_o(pc_plus), .flush_o(flush),
        .ras_empty_o(empty), .ras_full_o(full), .ret_err_o(err)
    );

    pc_seq_unit #(.ISIZE(16), .RESET_VEC(16'hFFFE), .STEP(2), .RAS_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .stall_i(1'b0), .branch_i(1'b0),
        .branch_target_i(16'h0000), .call_i(1'b0), .ret_i(1'b0),
        .pc_o(pc2), .pc_plus_o(pc_plus2), .flush_o(flush2),
        .ras_empty_o(empty2), .ras_full_o(full2), .ret_err_o(err2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch = 0; call = 0; ret = 0; target = 16'h0000;
    endtask

    initial begin
        logic err_exp;
`ifdef PC_RAS_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        idle();
        rst = 1;
        step();
        rst = 0;
        chk("reset_pc", pc, 16'h0010);
        chk("reset_pc_plus", pc_plus, 16'h0011);
        chk("reset_flush", {15'd0, flush}, 16'd0);
        chk("reset_empty", {15'd0, empty}, 16'd1);
        chk("reset_full", {15'd0, full}, 16'd0);
        chk("reset_err", {15'd0, err}, 16'd0);
        chk("wrap_reset_pc", pc2, 16'hFFFE);
        chk("wrap_reset_plus", pc_plus2, 16'h0000);

        step();
        chk("run_pc1", pc, 16'h0011);
        chk("wrap_pc", pc2, 16'h0000);
        chk("wrap_plus", pc_plus2, 16'h0002);
        step();
        chk("run_pc2", pc, 16'h0012);
        chk("run_flush", {15'd0, flush}, 16'd0);

        stall = 1;
        step();
        chk("stall_pc", pc, 16'h0012);
        chk("stall_flush", {15'd0, flush}, 16'd0);
        branch = 1; target = 16'h0200;
        step();
        idle();
        chk("stall_branch_pc", pc, 16'h0200);
        chk("stall_branch_flush", {15'd0, flush}, 16'd1);
        step();
        chk("post_branch_pc", pc, 16'h0201);
        chk("post_branch_flush", {15'd0, flush}, 16'd0);

        ret = 1;
        step();
        idle();
        chk("empty_ret_pc", pc, 16'h0202);
        chk("empty_ret_flush", {15'd0, flush}, 16'd0);
        chk("empty_ret_err", {15'd0, err}, {15'd0, err_exp});

        call = 1;
        step();
        idle();
        chk("lone_call_pc", pc, 16'h0203);
        chk("lone_call_empty", {15'd0, empty}, 16'd1);

`ifdef PC_RAS_EN
        branch = 1; target = 16'h0020;
        step();
        branch = 1; call = 1; target = 16'h0100;
        step();
        idle();
        chk("call1_pc", pc, 16'h0100);
        chk("call1_flush", {15'd0, flush}, 16'd1);
        chk("call1_empty", {15'd0, empty}, 16'd0);
        step();
        branch = 1; call = 1; target = 16'h0300;
        step();
        idle();
        chk("call2_pc", pc, 16'h0300);
        ret = 1;
        step();
        chk("ret1_pc", pc, 16'h0102);
        chk("ret1_flush", {15'd0, flush}, 16'd1);
        step();
        idle();
        chk("ret2_pc", pc, 16'h0021);
        chk("ret2_flush", {15'd0, flush}, 16'd1);
        chk("ret2_empty", {15'd0, empty}, 16'd1);

        for (int i = 0; i < 5; i++) begin
            branch = 1; call = 1; target = 16'h0400 + 16'(i) * 16'h0100;
            step();
            if (i == 3) chk("push4_full", {15'd0, full}, 16'd1);
        end
        idle();
        chk("push5_full", {15'd0, full}, 16'd1);
        chk("push5_pc", pc, 16'h0800);
        ret = 1;
        step();
        chk("deep_ret1", pc, 16'h0701);
        chk("deep_ret1_full", {15'd0, full}, 16'd0);
        step();
        chk("deep_ret2", pc, 16'h0601);
        step();
        chk("deep_ret3", pc, 16'h0501);
        step();
        chk("deep_ret4", pc, 16'h0401);
        chk("deep_ret4_empty", {15'd0, empty}, 16'd1);
        step();
        idle();
        chk("deep_ret5_pc", pc, 16'h0402);
        chk("deep_ret5_flush", {15'd0, flush}, 16'd0);
        chk("deep_ret5_err", {15'd0, err}, 16'd1);

        branch = 1; call = 1; target = 16'h0A00;
        step();
        idle();
        stall = 1; ret = 1;
        step();
        idle();
        chk("stall_ret_pc", pc, 16'h0403);
        chk("stall_ret_flush", {15'd0, flush}, 16'd1);
`endif

        branch = 1; ret = 1; target = 16'h0900;
        step();
        idle();
        chk("branch_ret_pc", pc, 16'h0900);
        chk("branch_ret_flush", {15'd0, flush}, 16'd1);
        chk("sticky_err", {15'd0, err}, {15'd0, err_exp});

        rst = 1; branch = 1; call = 1; target = 16'h0777;
        step();
        rst = 0;
        idle();
        chk("rst_branch_pc", pc, 16'h0010);
        chk("rst_branch_flush", {15'd0, flush}, 16'd0);
        chk("rst_branch_empty", {15'd0, empty}, 16'd1);
        chk("rst_branch_err", {15'd0, err}, 16'd0);
        step();
        chk("rst_after_pc", pc, 16'h0011);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter unit for the three-stage pipeline. Holds the fetch address and advances it by a configurable step each cycle, with stall hold, taken-branch redirect and registered flush indication. An optional return-address stack (RAS) supports call/return redirects. Sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
Parameters:
- `ISIZE`, default 16: PC width in bits.
- `RESET_VEC`, default 0: PC value loaded on reset.
- `STEP`, default 1: sequential increment, in instruction-memory words.
- `RAS_DEPTH`, default 4: number of RAS entries; must be ≥2. Used only when the RAS is compiled in.

Ports (clock and reset first):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall_i` input 1: hold the PC.
- `branch_i` input 1: taken branch or jump.
- `branch_target_i` input ISIZE: redirect address.
- `call_i` input 1: current branch is a call; valid only with `branch_i`.
- `ret_i` input 1: return; redirect to the RAS top.
- `pc_o` output ISIZE: current fetch address (registered).
- `pc_plus_o` output ISIZE: `pc_o + STEP`, combinational, modulo 2^ISIZE.
- `flush_o` output 1: registered; high for one cycle after a redirect.
- `ras_empty_o` output 1: RAS holds no entries.
- `ras_full_o` output 1: RAS holds `RAS_DEPTH` entries.
- `ret_err_o` output 1: sticky flag; a return was issued while the RAS was empty.

## Operation
- Reset values: `pc_o` = RESET_VEC, `flush_o` = 0, RAS count = 0, `ras_empty_o` = 1, `ras_full_o` = 0, `ret_err_o` = 0.
- `rst` overrides every other input on the same edge.
- Next-PC priority on each edge with `rst` = 0:
  - `branch_i`: `pc_o` ← `branch_target_i`. Applies even when `stall_i` = 1. `flush_o` ← 1. If `call_i` is also high, push `pc_plus_o`.
  - `ret_i` with a non-empty RAS: `pc_o` ← RAS top and pop. `flush_o` ← 1. Applies even when `stall_i` = 1.
  - `ret_i` with an empty RAS: treated as no redirect. `ret_err_o` ← 1. Fall through to the next two rules.
  - `stall_i`: `pc_o` holds.
  - Otherwise: `pc_o` ← `pc_o + STEP`, wrapping modulo 2^ISIZE (0xFFFF + 1 → 0x0000 at ISIZE=16).
- `flush_o` is 0 on every edge that takes no redirect.
- `call_i` without `branch_i` is ignored: no push.
- `branch_i` and `ret_i` together: the branch wins and no pop occurs. The push still happens if `call_i` is high.
- RAS is a circular LIFO:
  - Push when full overwrites the oldest entry; the count stays at `RAS_DEPTH`.
  - Pop when empty does not change state.
- `ret_err_o` clears only on `rst`.

## Timing
- Single-cycle latency: inputs sampled at edge N determine `pc_o` after edge N.
- `flush_o` is asserted during the cycle in which the redirected `pc_o` is first presented. The pipeline uses it to squash the instruction fetched in the previous cycle.
- `pc_plus_o` follows `pc_o` combinationally with no added cycle.
- RAS status flags are registered and update on the same edge as the push or pop.
- Reset mid-stream: the edge with `rst` = 1 discards any pending branch, call or ret. On the following cycle `pc_o` = RESET_VEC and the RAS is empty.

## Configuration
- Macro `PC_RAS_EN`, defined in `define.v`.
- Defined: RAS, `call_i`/`ret_i` handling and `ret_err_o` behave as described above.
- Undefined: no RAS storage is built.
  - `call_i` and `ret_i` are ignored; `ret_i` never redirects.
  - `ras_empty_o` is tied to 1, and `ras_full_o` and `ret_err_o` are tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset, then 3 free-running cycles (ISIZE=16, STEP=1, RESET_VEC=0x0010) → `pc_o` = 0x0010, 0x0011, 0x0012, 0x0013; `flush_o` stays 0.
- `stall_i` high for 2 cycles at PC 0x0012, with `branch_i` pulsed on the 2nd cycle to target 0x0200 → `pc_o` holds 0x0012, then becomes 0x0200 with `flush_o` = 1 for exactly one cycle.
- PC at 0xFFFE, STEP=2, free-running → `pc_o` = 0x0000 next cycle; `pc_plus_o` = 0x0002.
- With `PC_RAS_EN`: call at PC 0x0020 to 0x0100, call at 0x0104 to 0x0300, then two rets → `pc_o` = 0x0105, then 0x0021. `ras_empty_o` = 1 after the second return; `flush_o` pulses on each redirect.
- With `PC_RAS_EN`, RAS_DEPTH=4: 5 pushes then 5 rets → the first 4 returns hit in LIFO order and `ras_full_o` = 1 after the 4th push. The 5th return leaves the RAS empty, `pc_o` increments normally and `ret_err_o` = 1.
- `rst` asserted in the same cycle as `branch_i` and `call_i` → `pc_o` = RESET_VEC, `flush_o` = 0, `ras_empty_o` = 1.
